intensity_pwm: RTL

- Consumes the 4-bit proximity intensity (0 = far/none, 8 = closest) from the distance stage.
- Drives a slew-limited PWM output, for a haptic motor or LED, whose duty cycle tracks that intensity.
- Each level change is applied as one step per RAMP_PERIODS PWM periods, and duty updates only at period boundaries (glitch-free).
- Sits directly downstream of the distance/intensity stage, same 40 MHz clock domain.

---
 rtl/intensity_pkg.sv | 14 +
 rtl/pwm_tick_gen.sv | 41 ++++
 rtl/intensity_pwm.sv | 120 ++++++++++++
 3 files changed

// File: rtl/intensity_pkg.sv
// Shared types and defaults for the proximity-intensity PWM driver.
package intensity_pkg;

    localparam int DEF_MAX_LEVEL = 8;

    typedef logic [3:0] level_t;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN
    } ramp_state_t;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler and PWM period counter: one tick per PRESCALE clocks, one period per PERIOD ticks.
module pwm_tick_gen #(
    parameter int PRESCALE = 40,
    parameter int PERIOD   = 1000,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             reset,
    output logic             tick,
    output logic             period_end,
    output logic [CNT_W-1:0] pwm_cnt
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]    presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        tick        = (presc_cnt_q == PW'(PRESCALE - 1));
        period_end  = tick && (pwm_cnt_q == CNT_W'(PERIOD - 1));
        presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        pwm_cnt_d   = pwm_cnt_q;
        if (tick) begin
            pwm_cnt_d = period_end ? '0 : pwm_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
        end
    end

    assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/intensity_pwm.sv
// Slew-limited PWM driver: duty tracks the requested intensity one level per RAMP_PERIODS periods.
//   state     | meaning
//   IDLE      | level == target, holding
//   RAMP_UP   | counting periods before the next +1 step
//   RAMP_DOWN | counting periods before the next -1 step
module intensity_pwm
    import intensity_pkg::*;
#(
    parameter int PRESCALE     = 40,
    parameter int STEP_TICKS   = 125,
    parameter int MAX_LEVEL    = DEF_MAX_LEVEL,
    parameter int RAMP_PERIODS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] intensity,
    output logic       pwm_out,
    output logic [3:0] level,
    output logic       busy
);

    localparam int PERIOD = MAX_LEVEL * STEP_TICKS;
    localparam int CNT_W  = $clog2(PERIOD + 1);
    localparam int RW     = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

    logic             tick, period_end, frame_end;
    logic [CNT_W-1:0] pwm_cnt;

    ramp_state_t      state_q, state_d;
    level_t           target_q, target_d;
    level_t           level_q, level_d;
    logic [RW-1:0]    ramp_cnt_q, ramp_cnt_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             pwm_out_q, pwm_out_d;

    pwm_tick_gen #(
        .PRESCALE (PRESCALE),
        .PERIOD   (PERIOD),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .period_end (period_end),
        .pwm_cnt    (pwm_cnt)
    );

    assign frame_end = tick && period_end;

    always_comb begin
        target_d   = (intensity > level_t'(MAX_LEVEL)) ? level_t'(MAX_LEVEL) : intensity;
        state_d    = state_q;
        level_d    = level_q;
        ramp_cnt_d = ramp_cnt_q;
        duty_d     = duty_q;
        if (!enable) begin
            state_d    = IDLE;
            level_d    = '0;
            ramp_cnt_d = '0;
            duty_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ramp_cnt_d = '0;
                    if (target_q > level_q) begin
                        state_d = RAMP_UP;
                    end else if (target_q < level_q) begin
                        state_d = RAMP_DOWN;
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (target_q == level_q) begin
                        state_d    = IDLE;
                        ramp_cnt_d = '0;
                    end else if ((target_q > level_q) != (state_q == RAMP_UP)) begin
                        // target crossed the current level: turn around, restart the count
                        state_d    = (target_q > level_q) ? RAMP_UP : RAMP_DOWN;
                        ramp_cnt_d = '0;
                    end else if (frame_end) begin
                        if (ramp_cnt_q == RW'(RAMP_PERIODS - 1)) begin
                            ramp_cnt_d = '0;
                            level_d    = (state_q == RAMP_UP) ? level_q + 1'b1 : level_q - 1'b1;
                        end else begin
                            ramp_cnt_d = ramp_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (frame_end) begin
                duty_d = CNT_W'(level_d) * CNT_W'(STEP_TICKS);
            end
        end
        pwm_out_d = enable && (pwm_cnt < duty_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            target_q   <= '0;
            level_q    <= '0;
            ramp_cnt_q <= '0;
            duty_q     <= '0;
            pwm_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            level_q    <= level_d;
            ramp_cnt_q <= ramp_cnt_d;
            duty_q     <= duty_d;
            pwm_out_q  <= pwm_out_d;
        end
    end

    assign pwm_out = pwm_out_q;
    assign level   = level_q;
    assign busy    = enable && (level_q != target_q);

endmodule
